// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: buffers 128-bit I-cache lines and streams one 32-bit instruction + PC per cycle to decode.
// Optional feature macro IFQ_BYPASS_EN: a line returning into an empty queue is presented to decode in the same cycle.
module instruction_fetch_queue #(
  parameter int          DEPTH_LINES = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic         clock,
  input  logic         reset,
  output logic         Ifq_icache_rd_en,
  output logic [31:0]  Ifq_icache_addr,
  input  logic [127:0] Icache_dout,
  input  logic         Icache_dout_valid,
  output logic [31:0]  Ifq_inst,
  output logic [31:0]  Ifq_pc,
  output logic         Ifq_empty,
  input  logic         Dispatch_ren,
  input  logic         Dispatch_jmp,
  input  logic [31:0]  Dispatch_jmp_addr
);

  localparam int AW = $clog2(DEPTH_LINES);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                            state;
  logic [DEPTH_LINES-1:0][3:0][31:0] mem;
  logic [AW:0]                       wr_ptr, rd_ptr;
  logic [31:0]                       fetch_pc, rd_pc;
  logic [1:0]                        rd_word;
  logic                              full, q_empty, bypass, rd_fire, wr_fire;

  assign q_empty = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});

`ifdef IFQ_BYPASS_EN
  assign bypass = (state == WAIT) && Icache_dout_valid && q_empty;
`else
  assign bypass = 1'b0;
`endif

  assign Ifq_empty        = q_empty && !bypass;
  assign Ifq_pc           = rd_pc;
  assign Ifq_icache_addr  = fetch_pc;
  assign Ifq_icache_rd_en = !reset && (state == IDLE) && !Dispatch_jmp && !full;
  assign rd_fire          = Dispatch_ren && !Ifq_empty;
  assign wr_fire          = (state == WAIT) && Icache_dout_valid;

  always_comb begin
    Ifq_inst = 32'h0;
    if (bypass)
      Ifq_inst = Icache_dout[{rd_word, 5'b0} +: 32];
    else if (!q_empty)
      Ifq_inst = mem[rd_ptr[AW-1:0]][rd_word];
  end

  // Line storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clock) begin
    if (!reset && !Dispatch_jmp && wr_fire)
      mem[wr_ptr[AW-1:0]] <= Icache_dout;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fetch_pc <= RESET_PC;
      rd_pc    <= RESET_PC;
      rd_word  <= RESET_PC[3:2];
      state    <= IDLE;
    end else if (Dispatch_jmp) begin
      rd_ptr   <= wr_ptr;
      rd_pc    <= Dispatch_jmp_addr & ~32'h3;
      rd_word  <= Dispatch_jmp_addr[3:2];
      fetch_pc <= Dispatch_jmp_addr & ~32'hF;
      // A response landing in the redirect cycle already retires the stale request,
      // so only a still-outstanding one needs DROP.
      state    <= (state != IDLE && !Icache_dout_valid) ? DROP : IDLE;
    end else begin
      if (wr_fire) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 32'd16;
      end
      if (rd_fire) begin
        rd_pc   <= rd_pc + 32'd4;
        rd_word <= rd_word + 2'd1;
        if (rd_word == 2'd3)
          rd_ptr <= rd_ptr + 1'b1;
      end
      unique case (state)
        IDLE:    if (Ifq_icache_rd_en) state <= WAIT;
        WAIT:    if (Icache_dout_valid) state <= IDLE;
        DROP:    if (Icache_dout_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
